// File: rtl/rect_ctl.sv
// Frame-rate rectangle position controller: tracks the mouse, falls under gravity on click.
// Define RECT_CTL_BOUNCE_EN to enable damped rebounds off the floor; otherwise floor hits come to rest.
module rect_ctl #(
    parameter int unsigned SCREEN_HEIGHT = 600,
    parameter int unsigned RECT_HEIGHT   = 64,
    parameter int unsigned GRAVITY       = 4,
    parameter int unsigned V_MIN         = 16
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  state
);
    localparam logic [11:0] YMAX    = 12'(SCREEN_HEIGHT - RECT_HEIGHT);
    localparam logic [15:0] YMAX_FX = {YMAX, 4'b0000};
    localparam logic [11:0] GRAV    = 12'(GRAVITY);
    localparam logic [11:0] VMIN    = 12'(V_MIN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FALL   = 2'd1,
        S_BOUNCE = 2'd2,
        S_REST   = 2'd3
    } state_t;

    state_t      r_state;
    logic [11:0] r_xpos;
    logic [15:0] r_ypos_fx;
    logic [11:0] r_v;
    logic        r_vsync_d;
    logic        r_left_d;
    logic        r_pending;

    logic        w_tick;
    logic        w_press;
    logic        w_go;
    logic [11:0] w_ytrack;
    logic [16:0] w_sum;
    logic        w_floor;
    logic [12:0] w_vgrav;
    logic [11:0] w_vinc;
    logic [15:0] w_yup;
    logic [11:0] w_vr;
    logic        w_hit_bounce;

    assign w_tick   = vsync_in & ~r_vsync_d;
    assign w_press  = mouse_left & ~r_left_d;
    assign w_go     = w_press | r_pending;
    assign w_ytrack = (mouse_ypos > YMAX) ? YMAX : mouse_ypos;

    // Fall step uses the pre-update velocity; velocity saturates rather than wrapping.
    assign w_sum   = 17'(r_ypos_fx) + 17'(r_v);
    assign w_floor = (w_sum >= 17'(YMAX_FX));
    assign w_vgrav = 13'(r_v) + 13'(GRAV);
    assign w_vinc  = w_vgrav[12] ? 12'hFFF : w_vgrav[11:0];
    assign w_yup   = (r_ypos_fx >= 16'(r_v)) ? (r_ypos_fx - 16'(r_v)) : 16'd0;

`ifdef RECT_CTL_BOUNCE_EN
    assign w_vr         = r_v - (r_v >> 2);
    assign w_hit_bounce = (w_vr >= VMIN);
`else
    assign w_vr         = 12'd0;
    assign w_hit_bounce = 1'b0 & (VMIN != 12'd0);
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_xpos    <= 12'd0;
            r_ypos_fx <= 16'd0;
            r_v       <= 12'd0;
            r_vsync_d <= 1'b0;
            r_left_d  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_vsync_d <= vsync_in;
            r_left_d  <= mouse_left;
            if (w_tick) begin
                r_pending <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        r_xpos    <= mouse_xpos;
                        r_ypos_fx <= {w_ytrack, 4'b0000};
                        r_v       <= 12'd0;
                        if (w_go) r_state <= S_FALL;
                    end
                    S_FALL: begin
                        if (w_floor) begin
                            r_ypos_fx <= YMAX_FX;
                            if (w_hit_bounce) begin
                                r_state <= S_BOUNCE;
                                r_v     <= w_vr;
                            end else begin
                                r_state <= S_REST;
                                r_v     <= 12'd0;
                            end
                        end else begin
                            r_ypos_fx <= w_sum[15:0];
                            r_v       <= w_vinc;
                        end
                    end
                    S_BOUNCE: begin
                        r_ypos_fx <= w_yup;
                        if (r_v <= GRAV) begin
                            r_v     <= 12'd0;
                            r_state <= S_FALL;
                        end else begin
                            r_v <= r_v - GRAV;
                        end
                    end
                    S_REST: begin
                        if (w_go) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_press) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign xpos  = r_xpos;
    assign ypos  = r_ypos_fx[15:4];
    assign state = r_state;

endmodule
